// File: rtl/logic_op_pipe_pkg.sv
// Shared types and the bitwise operation helper for logic_op_pipe.
package logic_op_pipe_pkg;

  localparam int unsigned OP_W      = 2;
  // Widest operand the helper handles; callers zero-extend and truncate.
  localparam int unsigned MAX_WIDTH = 256;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  function automatic logic [MAX_WIDTH-1:0] apply_op(
    input op_e                  op,
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b
  );
    logic [MAX_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_fifo.sv
// Synchronous FIFO with occupancy count and a registered head that holds
// the last popped entry while empty.
module logic_op_fifo #(
  parameter int unsigned WIDTH_DATA = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [WIDTH_DATA-1:0]   wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [WIDTH_DATA-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH_DATA-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [CNT_W-1:0]      count_nxt;
  logic [WIDTH_DATA-1:0] head_nxt;
  logic                  push;
  logic                  pop;

  assign wr_ready = (count != CNT_W'(DEPTH));
  assign rd_valid = (count != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  // Next head: the entry being written now if it lands at the new read
  // pointer (FIFO empty after this edge's pop), otherwise stored data.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    head_nxt   = rd_data;
    if (pop) rd_ptr_nxt = rd_ptr + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    if (count_nxt != '0) begin
      if (push && (wr_ptr == rd_ptr_nxt)) head_nxt = wr_data;
      else                                head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      rd_data <= head_nxt;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Bitwise AND/OR/XOR/NAND on operand pairs, results buffered in a FIFO.
// Define LOGIC_OP_PIPE_PARITY_EN to add a stored per-result out_parity port.
module logic_op_pipe
  import logic_op_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [OP_W-1:0]        in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_c,
  output logic                   out_zero,
  output logic [$clog2(DEPTH):0] out_count
`ifdef LOGIC_OP_PIPE_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

`ifdef LOGIC_OP_PIPE_PARITY_EN
  localparam int unsigned DATA_W = WIDTH + 2;
`else
  localparam int unsigned DATA_W = WIDTH + 1;
`endif

  logic [WIDTH-1:0]  result;
  logic              zero;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  assign result = WIDTH'(apply_op(op_e'(in_op), MAX_WIDTH'(in_a), MAX_WIDTH'(in_b)));
  assign zero   = ~|result;

`ifdef LOGIC_OP_PIPE_PARITY_EN
  assign wr_data    = {^result, zero, result};
  assign out_parity = rd_data[WIDTH+1];
`else
  assign wr_data    = {zero, result};
`endif
  assign out_c    = rd_data[WIDTH-1:0];
  assign out_zero = rd_data[WIDTH];

  logic_op_fifo #(
    .WIDTH_DATA (DATA_W),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (wr_data),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (rd_data),
    .count    (out_count)
  );

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe (WIDTH=8, DEPTH=4).
module tb_logic_op_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_c;
  logic       out_zero;
  logic [2:0] out_count;
`ifdef LOGIC_OP_PIPE_PARITY_EN
  logic       out_parity;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_ops [4];

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_c      (out_c),
    .out_zero   (out_zero),
    .out_count  (out_count)
`ifdef LOGIC_OP_PIPE_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_ops[0] = 8'h30;
    exp_ops[1] = 8'hFC;
    exp_ops[2] = 8'hCC;
    exp_ops[3] = 8'hCF;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_c", 32'(out_c), 32'h00);
    chk("reset_out_zero", 32'(out_zero), 32'd0);
    chk("reset_out_count", 32'(out_count), 32'd0);

    // One operation per code, streaming through with the consumer ready.
    out_ready = 1'b1;
    in_a = 8'hF0; in_b = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_op    = 2'(i);
      step();
      chk($sformatf("op%0d_out_c", i), 32'(out_c), 32'(exp_ops[i]));
      chk($sformatf("op%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("op%0d_zero", i), 32'(out_zero), 32'd0);
      chk($sformatf("op%0d_count", i), 32'(out_count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold_c", 32'(out_c), 32'hCF);
    chk("drain_count", 32'(out_count), 32'd0);

    // Fill with the consumer stalled.
    out_ready = 1'b0;
    in_a = 8'hFF; in_op = 2'd0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill%0d_ready", i), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_b     = 8'(i);
      step();
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(out_count), 32'd4);
    chk("full_head", 32'(out_c), 32'h00);
    chk("full_head_zero", 32'(out_zero), 32'd1);
    in_b = 8'h09;
    step(); step();
    chk("full_reject_count", 32'(out_count), 32'd4);
    chk("full_reject_head", 32'(out_c), 32'h00);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("full_pop_ready_low", 32'(in_ready), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("release%0d_head", i), 32'(out_c), 32'(i));
      chk($sformatf("release%0d_zero", i), 32'(out_zero), 32'd0);
      chk($sformatf("release%0d_count", i), 32'(out_count), 32'(4 - i));
      chk($sformatf("release%0d_ready", i), 32'(in_ready), 32'd1);
    end
    step();
    chk("release_empty_valid", 32'(out_valid), 32'd0);
    chk("release_hold_c", 32'(out_c), 32'h03);

    // Preload two, then push and pop together for ten cycles.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'hFF; in_op = 2'd0;
    in_b = 8'h10; step();
    in_b = 8'h11; step();
    chk("pp_pre_count", 32'(out_count), 32'd2);
    chk("pp_pre_head", 32'(out_c), 32'h10);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_b = 8'(8'h12 + k);
      step();
      chk($sformatf("pp%0d_count", k), 32'(out_count), 32'd2);
      chk($sformatf("pp%0d_head", k), 32'(out_c), 32'(8'h11 + k));
    end
    in_valid = 1'b0;
    step();
    chk("pp_drain_head", 32'(out_c), 32'h1B);
    chk("pp_drain_count", 32'(out_count), 32'd1);
    step();
    chk("pp_empty_valid", 32'(out_valid), 32'd0);

    // Mid-burst reset with three entries held.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h00; in_op = 2'd1;
    for (int i = 1; i <= 3; i++) begin
      in_b = 8'(8'h20 + i);
      step();
    end
    in_valid = 1'b0;
    chk("mid_pre_count", 32'(out_count), 32'd3);
    chk("mid_pre_head", 32'(out_c), 32'h21);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(out_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_c", 32'(out_c), 32'h00);
    #1;
    rst = 1'b0;
    in_valid = 1'b1; in_a = 8'h5A; in_b = 8'hFF; in_op = 2'd0;
    step();
    in_valid = 1'b0;
    chk("post_rst_head", 32'(out_c), 32'h5A);
    chk("post_rst_count", 32'(out_count), 32'd1);
    out_ready = 1'b1;
    step();
    chk("post_rst_empty", 32'(out_valid), 32'd0);
    chk("post_rst_hold", 32'(out_c), 32'h5A);

    // NAND of all ones gives zero at full width.
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_op = 2'd3;
    step();
    in_valid = 1'b0;
    chk("nand_ones_c", 32'(out_c), 32'h00);
    chk("nand_ones_zero", 32'(out_zero), 32'd1);
    step();

`ifdef LOGIC_OP_PIPE_PARITY_EN
    in_valid = 1'b1; in_op = 2'd2; in_a = 8'h07; in_b = 8'h00;
    step();
    chk("par_07_c", 32'(out_c), 32'h07);
    chk("par_07_parity", 32'(out_parity), 32'd1);
    in_a = 8'h03;
    step();
    in_valid = 1'b0;
    chk("par_03_c", 32'(out_c), 32'h03);
    chk("par_03_parity", 32'(out_parity), 32'd0);
    step();
    chk("par_hold", 32'(out_parity), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_op_pipe.md
# logic_op_pipe

Parametrised, buffered successor to the single-bit two-input AND gate: applies one of four bitwise operations (AND, OR, XOR, NAND) to WIDTH-bit operand pairs and queues the results in an output FIFO. Both sides use a valid/ready handshake. It sits between an operand source and a result consumer that may stall.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)
- DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept this cycle
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_op  input  2  operation: 0 AND, 1 OR, 2 XOR, 3 NAND
- out_valid  output  1  result at FIFO head
- out_ready  input  1  consumer takes head this cycle
- out_c  output  WIDTH  result at head
- out_zero  output  1  head result is all zeros
- out_count  output  $clog2(DEPTH)+1  entries held

## Operation
- Accept: in_valid && in_ready. The result op(in_a, in_b) and its zero flag are computed combinationally and written to the FIFO tail on that edge.
- Pop: out_valid && out_ready. The head advances on that edge.
- in_ready = (out_count < DEPTH). There is no write-through when full, even if a pop happens in the same cycle.
- out_valid = (out_count != 0).
- out_c and out_zero show head storage. When empty, they hold the last popped value (reset value 0).
- Simultaneous accept and pop: count unchanged, both pointers advance.
- Accept only: count +1. Pop only: count −1.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- NAND is ~(a & b) at full WIDTH. No carries, no width extension.
- in_op is sampled only on accept. Its value is irrelevant otherwise.
- Reset (any time, including mid-burst):
  - Flushes the FIFO: pointers 0, count 0.
  - out_valid 0, in_ready 1, out_c 0, out_zero 0, out_count 0.
  - Stored entries are discarded.

## Timing
- Latency: accepted on edge N, visible at out_c/out_valid after edge N (cycle N+1).
- Throughput: one result per cycle while out_ready stays high.
- in_ready and out_valid are functions of registered state only. No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Full, with out_ready high: in_ready stays low this cycle and rises the next cycle.
- Inputs must be stable around the clk edge. Operand changes while not accepted have no effect.

## Configuration
- LOGIC_OP_PIPE_PARITY_EN
  - Defined:
    - Adds an output port out_parity (1 bit), the XOR-reduction of the head result.
    - Stored per entry alongside out_zero.
    - Reset value 0; holds the last popped value when empty, like out_c.
  - Undefined: the port and storage are absent. All other behaviour is identical.

## Structure
- Package logic_op_pipe_pkg:
  - op_e enum (OP_AND=0, OP_OR=1, OP_XOR=2, OP_NAND=3)
  - function apply_op(op_e, a, b)
- Sub-module logic_op_fifo:
  - Generic WIDTH_DATA × DEPTH synchronous FIFO with count.
  - Asynchronous active-high reset on the same clk/rst.
  - Instantiated once, with data = {parity?, zero, result}.
- Top level holds only the op decode, the flag computation and handshake glue.

## Test plan
- Reset then idle, WIDTH=8 -> in_ready=1, out_valid=0, out_c=0x00, out_count=0.
- Single op per code, out_ready=1:
  - a=0xF0, b=0x3C, op 0..3 -> out_c 0x30, 0xFC, 0xCC, 0xCF on successive cycles.
  - Each appears one cycle after accept; out_zero=0.
- Fill with out_ready=0, DEPTH=4: accept four AND ops with a=0xFF, b=i -> in_ready=0 after the 4th, out_count=4. A 5th in_valid is not accepted. Release out_ready -> heads 0,1,2,3 in order; out_zero=1 only for the first.
- Simultaneous push/pop at count=2 over 10 cycles -> out_count stays 2, order preserved across pointer wrap.
- Mid-burst reset with count=3 (rst high between edges) -> out_valid drops immediately, count=0. Post-reset, the first accepted result appears with no stale data.
- With LOGIC_OP_PIPE_PARITY_EN, XOR a=0x07, b=0x00 -> out_c=0x07, out_parity=1. a=0x03, b=0x00 -> out_parity=0.
